// File: rtl/seq_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_if
//
// Bundles the producer-side word handshake and the serial output toward the
// sequence detector for seq_bit_serializer.
//
// Signals:
//   data_in    [WIDTH]  parallel word from producer
//   data_valid          producer has a word on data_in
//   data_ready          serializer can accept a word this cycle
//   ser_bit             serial bit, drives the detector's inp_bit
//   ser_valid           ser_bit carries a data bit (not idle fill)
//   word_done           last bit of a word is on ser_bit this cycle
//   busy                shifter active or holding buffer occupied
//
// Modports:
//   master  producer / observer side (drives data_in, data_valid)
//   slave   serializer side (drives ready and all serial outputs)
// -----------------------------------------------------------------------------
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  ser_bit,
    input  ser_valid,
    input  word_done,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output ser_bit,
    output ser_valid,
    output word_done,
    output busy
  );

endinterface

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//
// Parallel-to-serial front end for the sequence detector. Words of WIDTH bits
// are accepted over a valid/ready handshake into a one-entry holding buffer,
// then shifted out one bit per clock on ser_bit. Because the buffer refills
// while the shifter is busy, a continuously valid producer streams words with
// no idle bits in between. When nothing is shifting, ser_bit carries IDLE_BIT.
//
// Parameters:
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: data_in[WIDTH-1] leaves first, 0: data_in[0] leaves first
//   IDLE_BIT   fill value on ser_bit while idle
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    seq_bit_serializer_if.slave (handshake + serial outputs); the
//          interface instance must be built with the same WIDTH
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_bit_serializer_if.slave  bus
);

  // Counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] buf_r;
  logic             buf_full_r;
  logic             ser_bit_r;
  logic             ser_valid_r;
  logic             word_done_r;

  logic             ready_s;
  logic             accept_s;
  logic             load_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] shift_nxt_s;

  // Bit that sits at the output end of a word for the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Advance the word by one position toward the output end, zero fill.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Ready depends only on registered buffer state (and reset), never on valid.
  assign ready_s     = ~buf_full_r & ~reset;
  assign accept_s    = bus.data_valid & ready_s;
  assign last_bit_s  = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
  // The shifter takes the buffered word when idle or when its current word
  // ends; ready is low while full, so accept and load never coincide.
  assign load_s      = buf_full_r & ((state_r == ST_IDLE) | last_bit_s);
  assign shift_nxt_s = shift_word(shift_r);

  // Holding buffer, shifter FSM and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      cnt_r       <= '0;
      buf_r       <= '0;
      buf_full_r  <= 1'b0;
      ser_bit_r   <= IDLE_BIT;
      ser_valid_r <= 1'b0;
      word_done_r <= 1'b0;
    end else begin
      if (accept_s) begin
        buf_r      <= bus.data_in;
        buf_full_r <= 1'b1;
      end else if (load_s) begin
        buf_full_r <= 1'b0;
      end else begin
        buf_full_r <= buf_full_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (buf_full_r) begin
            state_r     <= ST_SHIFT;
            shift_r     <= buf_r;
            cnt_r       <= '0;
            ser_bit_r   <= head_bit(buf_r);
            ser_valid_r <= 1'b1;
            // WIDTH >= 2, so bit 0 is never the last bit.
            word_done_r <= 1'b0;
          end else begin
            ser_bit_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
            word_done_r <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            if (buf_full_r) begin
              // Gapless hand-over to the next buffered word.
              shift_r     <= buf_r;
              cnt_r       <= '0;
              ser_bit_r   <= head_bit(buf_r);
              ser_valid_r <= 1'b1;
              word_done_r <= 1'b0;
            end else begin
              state_r     <= ST_IDLE;
              cnt_r       <= '0;
              ser_bit_r   <= IDLE_BIT;
              ser_valid_r <= 1'b0;
              word_done_r <= 1'b0;
            end
          end else begin
            shift_r     <= shift_nxt_s;
            cnt_r       <= cnt_r + CNT_ONE;
            ser_bit_r   <= head_bit(shift_nxt_s);
            ser_valid_r <= 1'b1;
            word_done_r <= ((cnt_r + CNT_ONE) == CNT_LAST);
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          ser_bit_r   <= IDLE_BIT;
          ser_valid_r <= 1'b0;
          word_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_ready = ready_s;
  assign bus.ser_bit    = ser_bit_r;
  assign bus.ser_valid  = ser_valid_r;
  assign bus.word_done  = word_done_r;
  assign bus.busy       = (state_r == ST_SHIFT) | buf_full_r;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//
// Two serializer instances: dut_m (MSB first) and dut_l (LSB first), both
// WIDTH 8 with IDLE_BIT 0. Words sent to dut_m have their expected bits pushed
// to a queue at the moment of acceptance; a monitor pops and compares them as
// ser_valid bits appear. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) bus_m ();
  seq_bit_serializer_if #(.WIDTH(W)) bus_l ();

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  int checks = 0;
  int errors = 0;

  bit               exp_q[$];
  bit               exp_last_q[$];
  logic [W-1:0]     send_q[$];
  int               stall_cnt;
  int               accept_cnt;
  int               run_len;
  int               max_run;

  // Scoreboard: every negedge, compare a valid bit with the queue head, or
  // check idle fill when nothing is valid. Also tracks the longest valid run.
  task automatic monitor_loop();
    bit eb;
    bit el;
    forever begin
      @(negedge clk);
      if (bus_m.ser_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_bit: got ser_bit=%b with no bit expected", bus_m.ser_bit);
        end else begin
          eb = exp_q.pop_front();
          el = exp_last_q.pop_front();
          if (bus_m.ser_bit !== eb || bus_m.word_done !== el) begin
            errors++;
            $display("FAIL sb_bit: got ser_bit=%b word_done=%b, required %b %b",
                     bus_m.ser_bit, bus_m.word_done, eb, el);
          end
        end
      end else begin
        run_len = 0;
        checks++;
        if (bus_m.ser_bit !== 1'b0 || bus_m.word_done !== 1'b0) begin
          errors++;
          $display("FAIL sb_idle_fill: got ser_bit=%b word_done=%b, required 0 0",
                   bus_m.ser_bit, bus_m.word_done);
        end
      end
    end
  endtask

  // Present send_q to dut_m with data_valid held high; push expected bits on
  // each acceptance. Returns at the negedge after the final acceptance.
  task automatic drive_queue();
    int guard;
    logic [W-1:0] word;
    guard = 0;
    stall_cnt = 0;
    accept_cnt = 0;
    forever begin
      @(negedge clk);
      if (send_q.size() == 0) begin
        bus_m.data_valid = 1'b0;
        break;
      end
      if (guard >= 200) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: %0d words unaccepted, required 0", send_q.size());
        bus_m.data_valid = 1'b0;
        send_q.delete();
        break;
      end
      guard++;
      word = send_q[0];
      bus_m.data_in = word;
      bus_m.data_valid = 1'b1;
      if (bus_m.data_ready === 1'b1) begin
        for (int i = W - 1; i >= 0; i--) begin
          exp_q.push_back(word[i]);
          exp_last_q.push_back(i == 0);
        end
        void'(send_q.pop_front());
        accept_cnt++;
      end else begin
        stall_cnt++;
      end
    end
  endtask

  // Wait (bounded) until dut_m has emitted every expected bit and gone idle.
  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus_m.busy !== 1'b0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus_m.data_in = '0;
    bus_m.data_valid = 1'b0;
    bus_l.data_in = '0;
    bus_l.data_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_m.data_ready !== 1'b0 || bus_l.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_gate: got %b/%b, required 0/0", bus_m.data_ready, bus_l.data_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus_m.ser_bit !== 1'b0 || bus_m.ser_valid !== 1'b0 || bus_m.busy !== 1'b0 ||
          bus_m.word_done !== 1'b0 || bus_m.data_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got bit=%b valid=%b busy=%b done=%b ready=%b, required 0 0 0 0 1",
                 i, bus_m.ser_bit, bus_m.ser_valid, bus_m.busy, bus_m.word_done, bus_m.data_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_msb();
    max_run = 0;
    send_q.push_back(8'h99);
    drive_queue();
    checks++;
    if (bus_m.ser_valid !== 1'b0 || bus_m.busy !== 1'b1 || bus_m.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_buffered: got valid=%b busy=%b ready=%b, required 0 1 0",
               bus_m.ser_valid, bus_m.busy, bus_m.data_ready);
    end
    @(negedge clk);
    checks++;
    if (bus_m.ser_valid !== 1'b1 || bus_m.ser_bit !== 1'b1) begin
      errors++;
      $display("FAIL single_first_bit: got valid=%b bit=%b, required 1 1",
               bus_m.ser_valid, bus_m.ser_bit);
    end
    wait_drain();
    checks++;
    if (max_run !== 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_run: got run=%0d pending=%0d, required 8 0", max_run, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int low_cnt;
    max_run = 0;
    send_q.push_back(8'h90);
    send_q.push_back(8'h09);
    drive_queue();
    checks++;
    if (accept_cnt !== 2 || stall_cnt !== 1) begin
      errors++;
      $display("FAIL b2b_accepts: got accepts=%0d stalls=%0d, required 2 1", accept_cnt, stall_cnt);
    end
    low_cnt = 0;
    while (bus_m.data_ready !== 1'b1 && low_cnt < 50) begin
      low_cnt++;
      @(negedge clk);
    end
    checks++;
    if (low_cnt !== W - 1) begin
      errors++;
      $display("FAIL b2b_ready_low: got %0d cycles, required %0d", low_cnt, W - 1);
    end
    wait_drain();
    checks++;
    if (max_run !== 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_gapless: got run=%0d pending=%0d, required 16 0", max_run, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int low_cnt;
    max_run = 0;
    send_q.push_back(8'hA5);
    send_q.push_back(8'h3C);
    send_q.push_back(W'($urandom_range(0, 255)));
    drive_queue();
    checks++;
    if (accept_cnt !== 3 || stall_cnt !== 1 + (W - 1)) begin
      errors++;
      $display("FAIL bp_accepts: got accepts=%0d stalls=%0d, required 3 %0d",
               accept_cnt, stall_cnt, W);
    end
    low_cnt = 0;
    while (bus_m.data_ready !== 1'b1 && low_cnt < 50) begin
      low_cnt++;
      @(negedge clk);
    end
    checks++;
    if (low_cnt !== W - 1) begin
      errors++;
      $display("FAIL bp_ready_low: got %0d cycles, required %0d", low_cnt, W - 1);
    end
    wait_drain();
    checks++;
    if (max_run !== 24 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_stream: got run=%0d pending=%0d, required 24 0", max_run, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_word();
    int stray;
    send_q.push_back(8'hF0);
    send_q.push_back(8'hAB);
    drive_queue();
    // Now on bit 2 of 8'hF0; advance to bit 4.
    repeat (2) @(negedge clk);
    checks++;
    if (bus_m.ser_valid !== 1'b1 || bus_m.ser_bit !== 1'b1 || bus_m.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_fourth_bit: got valid=%b bit=%b busy=%b, required 1 1 1",
               bus_m.ser_valid, bus_m.ser_bit, bus_m.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus_m.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready_gate: got %b, required 0", bus_m.data_ready);
    end
    @(negedge clk);
    exp_q.delete();
    exp_last_q.delete();
    reset = 1'b0;
    #1;
    checks++;
    if (bus_m.ser_valid !== 1'b0 || bus_m.ser_bit !== 1'b0 || bus_m.busy !== 1'b0 ||
        bus_m.word_done !== 1'b0 || bus_m.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after: got valid=%b bit=%b busy=%b done=%b ready=%b, required 0 0 0 0 1",
               bus_m.ser_valid, bus_m.ser_bit, bus_m.busy, bus_m.word_done, bus_m.data_ready);
    end
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_m.ser_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL rst_mid_residual: got %0d valid bits, required 0", stray);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] word;
    int g;
    word = 8'h09;
    @(negedge clk);
    bus_l.data_in = word;
    bus_l.data_valid = 1'b1;
    checks++;
    if (bus_l.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL lsb_ready: got %b, required 1", bus_l.data_ready);
    end
    @(negedge clk);
    bus_l.data_valid = 1'b0;
    g = 0;
    while (bus_l.ser_valid !== 1'b1 && g < 5) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g !== 1) begin
      errors++;
      $display("FAIL lsb_latency: got %0d extra cycles, required 1", g);
    end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (bus_l.ser_valid !== 1'b1 || bus_l.ser_bit !== word[i] || bus_l.word_done !== (i == W - 1)) begin
        errors++;
        $display("FAIL lsb_bit%0d: got valid=%b bit=%b done=%b, required 1 %b %b",
                 i, bus_l.ser_valid, bus_l.ser_bit, bus_l.word_done, word[i], (i == W - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (bus_l.ser_valid !== 1'b0 || bus_l.ser_bit !== 1'b0) begin
      errors++;
      $display("FAIL lsb_return_idle: got valid=%b bit=%b, required 0 0",
               bus_l.ser_valid, bus_l.ser_bit);
    end
  endtask

  initial begin
    run_len = 0;
    max_run = 0;
    stall_cnt = 0;
    accept_cnt = 0;
    test_reset();
    fork
      monitor_loop();
    join_none
    test_single_msb();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_lsb_first();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
